unidade_execucao: RTL
=====================

# unidade_execucao

Execution stage downstream of the `banco_de_registradores` register bank. It consumes the two read operands (`Out_1`, `Out_2`), performs one of eight operations, and drives the bank's write-back port (`Data_to_write`, `Address_to_write`, `Signal_write`). Single-cycle ALU operations complete in 2 cycles. Multiplication is a 32-iteration shift-add sequence. A `Busy` handshake lets the control unit stall issue while an operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width.
- `ADDR_WIDTH`, 4: register address width (16 registers).

Ports:
- `Clock_in`  in  1  single clock; all state updates on the rising edge.
- `Signal_reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  issue strobe; sampled only when `Busy`=0.
- `Opcode`  in  3  operation select.
- `Operand_1`  in  WIDTH  first operand (bank `Out_1`).
- `Operand_2`  in  WIDTH  second operand (bank `Out_2`).
- `Dest_address`  in  ADDR_WIDTH  destination register.
- `Busy`  out  1  high while an accepted operation has not finished write-back.
- `Data_to_write`  out  WIDTH  result to the bank.
- `Address_to_write`  out  ADDR_WIDTH  destination to the bank.
- `Signal_write`  out  1  one-cycle write strobe to the bank.
- `Flag_zero`  out  1  result==0, valid with `Signal_write`, held until the next write-back.

## Operation
- Opcodes:
  - 000 ADD: `Operand_1`+`Operand_2`, mod 2^32.
  - 001 SUB: `Operand_1`−`Operand_2`, mod 2^32.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: signed two's-complement compare; result 1 if `Operand_1`<`Operand_2`, else 0.
  - 110 MUL: low 32 bits of the unsigned product.
  - 111 SHL: `Operand_1` << `Operand_2[4:0]`, zero-fill.
- All 8 opcodes are defined. There is no illegal-opcode path.
- Operands, `Opcode` and `Dest_address` are latched at the accepting edge. Input changes after that edge have no effect on the operation in flight.
- FSM states:
  - IDLE: `Start`=1 → EXEC (opcode≠110) or MUL (opcode=110).
  - EXEC: compute, then → WB.
  - MUL: multiplicand shifts left and multiplier shifts right each cycle, with a 5-bit counter. When the counter reaches 31 (32 iterations) → WB.
  - WB: `Signal_write`=1 for exactly one cycle → IDLE.
- Register 0 is not special. Writes to address 0 are issued normally.
- `Start` while `Busy`=1 is ignored: not queued, no side effects.

## Timing
- Reset (`Signal_reset`=0, asynchronous):
  - State returns to IDLE; MUL counter resets to 0.
  - `Busy`=0, `Signal_write`=0, `Data_to_write`=0, `Address_to_write`=0, `Flag_zero`=0.
- Reset asserted mid-operation aborts it. No write strobe is issued, even if deassertion comes later.
- Let edge k be the edge that accepts `Start`.
- `Busy` goes to 1 after edge k.
- ALU ops: result registered at edge k+1.
  - `Signal_write`=1 between edges k+1 and k+2; the bank captures at edge k+2.
  - `Busy` returns to 0 after edge k+2, so a new `Start` can be accepted at edge k+2 at the earliest (one operation per 2 cycles).
- MUL: iterations at edges k+1..k+32.
  - `Signal_write`=1 between edges k+32 and k+33.
  - `Busy` returns to 0 after edge k+33.
- `Data_to_write`, `Address_to_write` and `Flag_zero` are registered. They hold their last value outside the write strobe.
- `Start` and reset are not synchronised internally. Both are assumed synchronous to `Clock_in`, except the asynchronous assertion of reset.

## Test plan
- Reset: hold `Signal_reset`=0 for 2 cycles, release → all outputs 0, `Busy`=0; a `Start` in the first edge after release is accepted.
- ADD wrap: `Operand_1`=0xFFFFFFFF, `Operand_2`=2, `Dest_address`=3 → one-cycle `Signal_write` after edge k+1 with `Data_to_write`=0x00000001, `Address_to_write`=3, `Flag_zero`=0.
- SUB/SLT:
  - SUB 5−5 → `Data_to_write`=0, `Flag_zero`=1.
  - SLT 0xFFFFFFFF vs 1 → `Data_to_write`=1 (signed −1<1).
- MUL latency: `Operand_1`=7, `Operand_2`=6, `Dest_address`=7 → `Busy` high for 33 cycles; `Signal_write` only after edge k+32, `Data_to_write`=42; 0x10000×0x10000 → 0.
- Busy drop: issue MUL, pulse `Start` with ADD at edge k+5 → ADD ignored; only one write strobe (42) occurs.
- Reset mid-MUL: assert `Signal_reset`=0 at cycle k+10 → `Busy`=0 immediately, no `Signal_write` at any later cycle, next `Start` is accepted normally.

Source files
------------

// File: rtl/unidade_execucao.sv
// unidade_execucao: execution stage behind the register bank.
// Accepts one operation per Start when idle, computes it (one cycle for the
// ALU ops, 32 shift-add iterations for MUL) and presents the result on the
// bank write-back port with a one-cycle write strobe.
module unidade_execucao #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clock_in,
  input  logic                  Signal_reset,
  input  logic                  Start,
  input  logic [2:0]            Opcode,
  input  logic [WIDTH-1:0]      Operand_1,
  input  logic [WIDTH-1:0]      Operand_2,
  input  logic [ADDR_WIDTH-1:0] Dest_address,
  output logic                  Busy,
  output logic [WIDTH-1:0]      Data_to_write,
  output logic [ADDR_WIDTH-1:0] Address_to_write,
  output logic                  Signal_write,
  output logic                  Flag_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_WB   = 2'b11
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [2:0]              op_r;
  // a_r doubles as the multiplicand and b_r as the multiplier during MUL
  logic [WIDTH-1:0]        a_r;
  logic [WIDTH-1:0]        b_r;
  logic [WIDTH-1:0]        acc_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [ADDR_WIDTH-1:0]   dest_r;
  logic                    busy_r;
  logic                    we_r;
  logic [WIDTH-1:0]        data_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    zero_r;
  logic [WIDTH-1:0]        alu_s;
  logic [WIDTH-1:0]        partial_s;
  logic                    slt_s;

  assign Busy             = busy_r;
  assign Signal_write     = we_r;
  assign Data_to_write    = data_r;
  assign Address_to_write = addr_r;
  assign Flag_zero        = zero_r;

  // Next-state selection for the issue / execute / multiply / write-back FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          if (Opcode == OP_MUL) begin
            state_s = ST_MUL;
          end else begin
            state_s = ST_EXEC;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: state_s = ST_WB;
      ST_MUL: begin
        if (cnt_r == CNT_LAST) begin
          state_s = ST_WB;
        end else begin
          state_s = ST_MUL;
        end
      end
      ST_WB:   state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Single-cycle ALU result from the latched operands.
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    slt_s = ($signed(a_r) < $signed(b_r));
    case (op_r)
      OP_ADD:  alu_s = a_r + b_r;
      OP_SUB:  alu_s = a_r - b_r;
      OP_AND:  alu_s = a_r & b_r;
      OP_OR:   alu_s = a_r | b_r;
      OP_XOR:  alu_s = a_r ^ b_r;
      OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, slt_s};
      OP_SHL:  alu_s = a_r << b_r[CNT_W-1:0];
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add step: add the multiplicand when the multiplier LSB is set.
  always_comb begin
    if (b_r[0]) begin
      partial_s = acc_r + a_r;
    end else begin
      partial_s = acc_r;
    end
  end

  // FSM state register and the Busy flag derived from the next state.
  always_ff @(posedge Clock_in or negedge Signal_reset) begin
    if (!Signal_reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  // Operand latching at issue and the iterative multiplier datapath.
  always_ff @(posedge Clock_in or negedge Signal_reset) begin
    if (!Signal_reset) begin
      op_r   <= 3'b000;
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      acc_r  <= {WIDTH{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      dest_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            op_r   <= Opcode;
            a_r    <= Operand_1;
            b_r    <= Operand_2;
            dest_r <= Dest_address;
            acc_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
          end
        end
        ST_MUL: begin
          acc_r <= partial_s;
          a_r   <= a_r << 1;
          b_r   <= b_r >> 1;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered write-back port; values hold between strobes.
  always_ff @(posedge Clock_in or negedge Signal_reset) begin
    if (!Signal_reset) begin
      we_r   <= 1'b0;
      data_r <= {WIDTH{1'b0}};
      addr_r <= {ADDR_WIDTH{1'b0}};
      zero_r <= 1'b0;
    end else begin
      we_r <= 1'b0;
      case (state_r)
        ST_EXEC: begin
          we_r   <= 1'b1;
          data_r <= alu_s;
          addr_r <= dest_r;
          zero_r <= (alu_s == {WIDTH{1'b0}});
        end
        ST_MUL: begin
          if (cnt_r == CNT_LAST) begin
            we_r   <= 1'b1;
            data_r <= partial_s;
            addr_r <= dest_r;
            zero_r <= (partial_s == {WIDTH{1'b0}});
          end
        end
        default: begin
          we_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
